// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter steering one of eight requesters onto a shared 8:1 data mux.
// Each grant carries up to HOLD_MAX accepted beats; one ARB bubble separates grants.
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] data_in,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       out_valid,
  output logic       out_data,
  output logic [2:0] out_src,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t     r_state, w_next;
  logic [2:0] r_ptr, r_sel, r_src, w_win;
  logic [3:0] r_cnt;
  logic [7:0] r_grant;
  logic       w_any, w_accept, w_last, w_exit;

  assign w_any     = |req;
  assign out_valid = (r_state == XFER) && req[r_sel];
  assign out_data  = data_in[r_sel];
  assign w_accept  = out_valid && out_ready;
  assign w_last    = w_accept && (r_cnt == 4'(HOLD_MAX - 1));
  assign w_exit    = (r_state == XFER) && (!req[r_sel] || w_last);

  assign sel   = r_sel;
  assign out_src = r_src;
  assign grant = r_grant;
  assign busy  = (r_state != IDLE);

  // Scan from the far end back to ptr so the nearest set bit (ptr first) wins.
  always_comb begin
    logic [2:0] idx;
    w_win = 3'd0;
    idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = r_ptr + 3'(k);
      if (req[idx]) w_win = idx;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ARB;
      ARB:     w_next = w_any ? XFER : IDLE;
      XFER:    if (w_exit) w_next = w_any ? ARB : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= 3'd0;
      r_cnt   <= 4'd0;
      r_sel   <= 3'd0;
      r_src   <= 3'd0;
      r_grant <= 8'd0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_any) begin
            r_sel   <= w_win;
            r_src   <= w_win;
            r_grant <= 8'd1 << w_win;
          end
        end
        XFER: begin
          // Backpressure never ends a grant: counter only moves on accepted beats.
          if (w_exit) begin
            r_grant <= 8'd0;
            r_cnt   <= 4'd0;
            r_ptr   <= r_sel + 3'd1;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
